// File: rtl/keypad_pkg.sv
// Shared key codes, FSM states and frame helpers for the 4x4 keypad scanner.
// Optional stuck-key detection in the top is enabled by KEYPAD_STUCK_EN.
package keypad_pkg;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        DB_RELEASE
    } kp_state_t;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_SINGLE,
        FR_MULTI
    } frame_kind_t;

    typedef struct packed {
        frame_kind_t kind;
        logic [3:0]  code;
    } frame_cls_t;

    function automatic logic [3:0] keymap(
        input logic [1:0] row,
        input logic [1:0] col
    );
        logic [3:0] code;
        unique case ({row, col})
            4'h0:    code = 4'd1;
            4'h1:    code = 4'd2;
            4'h2:    code = 4'd3;
            4'h3:    code = KEY_A;
            4'h4:    code = 4'd4;
            4'h5:    code = 4'd5;
            4'h6:    code = 4'd6;
            4'h7:    code = KEY_B;
            4'h8:    code = 4'd7;
            4'h9:    code = 4'd8;
            4'hA:    code = 4'd9;
            4'hB:    code = KEY_C;
            4'hC:    code = KEY_STAR;
            4'hD:    code = 4'd0;
            4'hE:    code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    // Frame bit index is {row, col}; bits are active-high "key down".
    function automatic frame_cls_t classify(input logic [15:0] frame);
        frame_cls_t cls;
        logic [4:0] n;
        n        = '0;
        cls.code = '0;
        cls.kind = FR_NONE;
        for (int i = 0; i < 16; i++) begin
            if (frame[i]) begin
                n        = n + 5'd1;
                cls.code = keymap(2'(i / 4), 2'(i % 4));
            end
        end
        if (n == 5'd1) begin
            cls.kind = FR_SINGLE;
        end else if (n > 5'd1) begin
            cls.kind = FR_MULTI;
        end
        return cls;
    endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column divider, active-low column drive and frame assembly.
// Emits the completed 16-key frame with a one-cycle frame_done strobe.
import keypad_pkg::*;

module keypad_col_scan #(
    parameter int SCAN_DIV = 25000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [3:0]  row_sync,
    output logic [3:0]  col,
    output logic [15:0] frame,
    output logic        frame_done
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div_q;
    logic [1:0]    col_idx_q;
    logic [15:0]   frame_q;
    logic [15:0]   frame_d;
    logic          done_q;
    logic          tc;

    assign tc = (div_q == DIV_LAST);

    always_comb begin
        frame_d = frame_q;
        if (tc) begin
            for (int r = 0; r < 4; r++) begin
                frame_d[{2'(r), col_idx_q}] = ~row_sync[r];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_q     <= '0;
            col_idx_q <= 2'd0;
            frame_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            frame_q <= frame_d;
            done_q  <= tc && (col_idx_q == 2'd3);
            if (tc) begin
                div_q     <= '0;
                col_idx_q <= col_idx_q + 2'd1;
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

    assign col        = ~(4'b0001 << col_idx_q);
    assign frame      = frame_q;
    assign frame_done = done_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row sync, per-frame debounce FSM and key outputs.
// Define KEYPAD_STUCK_EN to flag keys held for STUCK_SCANS frames.
import keypad_pkg::*;

module keypad_scanner #(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 8,
    parameter int STUCK_SCANS    = 5000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] ITEM_CODE,
    output logic       KEY_PRESS,
    output logic       FUNC_KEY,
    output logic       MULTI_KEY,
    output logic       KEY_STUCK
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DB_N = CW'(DEBOUNCE_SCANS);

    logic [3:0]  sync1_q;
    logic [3:0]  sync2_q;
    logic [15:0] frame;
    logic        frame_done;
    frame_cls_t  cls;
    logic        hit;

    kp_state_t   state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  item_q, item_d;
    logic        press_q, press_d;
    logic        func_q, func_d;
    logic        multi_q, multi_d;
    logic        stuck_q, stuck_d;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= ROW;
            sync2_q <= sync1_q;
        end
    end

    keypad_col_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_col_scan (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .row_sync   (sync2_q),
        .col        (COL),
        .frame      (frame),
        .frame_done (frame_done)
    );

    assign cls = classify(frame);
    assign hit = (cls.kind == FR_SINGLE) && (cls.code == cand_q);

`ifdef KEYPAD_STUCK_EN
    localparam int SW = $clog2(STUCK_SCANS + 1);
    localparam logic [SW-1:0] STUCK_N = SW'(STUCK_SCANS);
    logic [SW-1:0] stk_q, stk_d;
`else
    logic unused_stuck;
    assign unused_stuck = (STUCK_SCANS > 0);
`endif

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        item_d  = item_q;
        press_d = press_q;
        func_d  = func_q;
        multi_d = multi_q;
        stuck_d = stuck_q;
`ifdef KEYPAD_STUCK_EN
        stk_d   = stk_q;
`endif
        if (frame_done) begin
            multi_d = (cls.kind == FR_MULTI);
            unique case (state_q)
                IDLE: begin
                    if (cls.kind == FR_SINGLE) begin
                        cand_d = cls.code;
                        cnt_d  = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = PRESSED;
                            item_d  = cls.code;
                            press_d = is_digit(cls.code);
                            func_d  = !is_digit(cls.code);
                            stuck_d = 1'b0;
`ifdef KEYPAD_STUCK_EN
                            stk_d   = '0;
`endif
                        end else begin
                            state_d = DB_PRESS;
                        end
                    end
                end
                DB_PRESS: begin
                    if (hit) begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_d == DB_N) begin
                            state_d = PRESSED;
                            item_d  = cand_q;
                            press_d = is_digit(cand_q);
                            func_d  = !is_digit(cand_q);
                            stuck_d = 1'b0;
`ifdef KEYPAD_STUCK_EN
                            stk_d   = '0;
`endif
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (hit) begin
`ifdef KEYPAD_STUCK_EN
                        if (!stuck_q) begin
                            stk_d = stk_q + SW'(1);
                            if (stk_d == STUCK_N) begin
                                stuck_d = 1'b1;
                                press_d = 1'b0;
                                func_d  = 1'b0;
                            end
                        end
`endif
                    end else begin
                        cnt_d = CW'(1);
                        if (cls.kind == FR_NONE && DEBOUNCE_SCANS == 1) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            press_d = 1'b0;
                            func_d  = 1'b0;
                            stuck_d = 1'b0;
                        end else begin
                            state_d = DB_RELEASE;
                        end
                    end
                end
                DB_RELEASE: begin
                    // Any non-matching key restarts release debounce: no rollover.
                    unique case (1'b1)
                        (cls.kind == FR_NONE): begin
                            cnt_d = cnt_q + CW'(1);
                            if (cnt_d == DB_N) begin
                                state_d = IDLE;
                                cnt_d   = '0;
                                press_d = 1'b0;
                                func_d  = 1'b0;
                                stuck_d = 1'b0;
                            end
                        end
                        hit: begin
                            state_d = PRESSED;
                        end
                        default: begin
                            cnt_d = '0;
                        end
                    endcase
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            item_q  <= '0;
            press_q <= 1'b0;
            func_q  <= 1'b0;
            multi_q <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            item_q  <= item_d;
            press_q <= press_d;
            func_q  <= func_d;
            multi_q <= multi_d;
            stuck_q <= stuck_d;
        end
    end

`ifdef KEYPAD_STUCK_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stk_q <= '0;
        end else begin
            stk_q <= stk_d;
        end
    end
    assign KEY_STUCK = stuck_q;
`else
    assign KEY_STUCK = 1'b0;
`endif

    assign ITEM_CODE = item_q;
    assign KEY_PRESS = press_q;
    assign FUNC_KEY  = func_q;
    assign MULTI_KEY = multi_q;

endmodule
